swerv_trace_buffer: RTL and testbench
=====================================

// Module: swerv_trace_buffer
// PURPOSE
//  Captures per-cycle retire trace (NUM_LANES instruction slots, trace_pkt_t layout generalised to N lanes),
//  buffers whole retire groups in a DEPTH-entry FIFO and serialises them to one instruction record per beat
//  on a valid/ready port for the debug/trace export path. Sits between dec_tlu trace outputs and the SoC trace sink.
// PARAMETERS
//  NUM_LANES  3   retire lanes per cycle (1..4)
//  DEPTH      8   FIFO entries (retire groups), power of two >=2
//  CNT_W      16  width of saturating drop counter
//  TS_W       32  timestamp width (used only with SWERV_TRACE_TIMESTAMP_EN)
// PORTS
//  clk                 in   1              core clock
//  rst                 in   1              asynchronous, active-high reset
//  trace_en            in   1              1 = capture enabled; 0 = no new captures, buffered data still drains
//  trace_valid_ip      in   NUM_LANES      per-lane retire valid
//  trace_insn_ip       in   32*NUM_LANES   per-lane instruction word, lane i at [32i+31:32i]
//  trace_address_ip    in   32*NUM_LANES   per-lane PC
//  trace_exception_ip  in   NUM_LANES      per-lane exception flag
//  trace_interrupt_ip  in   NUM_LANES      per-lane interrupt flag
//  trace_ecause_ip     in   5              cause, shared by group
//  trace_tval_ip       in   32             tval, shared by group
//  out_valid           out  1              record valid
//  out_ready           in   1              sink accepts record
//  out_lane            out  $clog2(NUM_LANES) source lane of record (1-bit min)
//  out_insn/out_addr   out  32/32          instruction / PC
//  out_exc/out_intr    out  1/1            exception / interrupt flag
//  out_ecause/out_tval out  5/32           group cause / tval (valid only when out_exc|out_intr)
//  out_lost            out  1              >=1 group dropped before this record
//  out_ts              out  TS_W           capture timestamp (only with SWERV_TRACE_TIMESTAMP_EN)
//  drop_cnt            out  CNT_W          dropped groups, saturating
//  fifo_level          out  $clog2(DEPTH)+1 occupied entries
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, lane pointer 0, lost flag 0, drop_cnt 0, timestamp 0.
//  - Capture: group pushed at edge when trace_en && |trace_valid_ip && (!full || pop_this_cycle).
//  - Drop: trace_en && |trace_valid_ip && full && !pop -> group discarded, drop_cnt+1 (holds at all-ones),
//    lost flag set. Lost flag clears on the handshake of the next record, which carries out_lost=1.
//  - Latency: group pushed at edge N into empty FIFO -> out_valid=1 in cycle N+1 (show-ahead head).
//  - Serialiser FSM IDLE/EMIT: IDLE while FIFO empty; EMIT presents head's lowest set valid lane.
//    out_valid&&out_ready advances to next set lane (ascending); on handshake of last set lane, head pops,
//    lane pointer resets; FSM stays EMIT if FIFO non-empty after pop, else IDLE. No bubble between groups.
//  - out_* are stable while out_valid && !out_ready (AXI-style: valid never withdrawn without handshake).
//  - Simultaneous push and pop at full: allowed, level unchanged, no drop.
//  - Pointers wrap mod DEPTH; level = wr_count - rd_count, range 0..DEPTH.
//  - trace_en falling mid-drain: draining continues; only captures stop.
//  - Reset asserted mid-record: record lost, all state back to reset values asynchronously.
// CONFIGURATION
//  SWERV_TRACE_TIMESTAMP_EN defined: free-running TS_W counter (+1 every clk, wraps), sampled into each
//   pushed group; out_ts carries it for every record of that group.
//  Undefined: no counter, no out_ts port, FIFO entry excludes timestamp field.
// STRUCTURE
//  swerv_types additions: trace_grp_t (per-lane valid/insn/addr/exc/intr arrays, ecause, tval, optional ts)
//   and TRACE_LANES constant; record fields remain flat ports.
//  Sub-module: swerv_trace_fifo (generic synchronous show-ahead FIFO, WIDTH/DEPTH params, push/pop/full/empty/level).
// TESTING
//  1 Single group valid=3'b101, insn lane0=0x00000013, lane2=0x00A00093, out_ready=1 -> two records
//    lane0 then lane2, first out_valid at cycle N+1, pop after second, fifo_level 1->0.
//  2 out_ready=0 for 5 cycles with record pending -> all out_* held constant, no pop.
//  3 Fill DEPTH=8 groups with out_ready=0, push 3 more -> drop_cnt=3, fifo_level=8; release ready ->
//    first record out_lost=0, first record pushed after drain space frees carries out_lost=1.
//  4 Full FIFO, last lane handshake and new group same cycle -> group accepted, drop_cnt unchanged.
//  5 trace_exception_ip=3'b010, ecause=5'd2, tval=0xDEADBEEF -> lane1 record out_exc=1, out_ecause=2,
//    out_tval=0xDEADBEEF; trace_en=0 with valid input -> no push, no drop count.
//  6 Reset pulse while emitting lane1 of 3-lane group -> outputs 0 immediately; with TIMESTAMP_EN,
//    next group pushed at ts=K reports out_ts=K on every lane.

Source files
------------

// File: rtl/swerv_trace_buffer_pkg.sv
// Shared types for the retire trace buffer: the buffered retire-group record and lane helpers.
// The optional timestamp field is present only when SWERV_TRACE_TIMESTAMP_EN is defined.
package swerv_trace_buffer_pkg;

    localparam int unsigned TRACE_LANES = 4;   // widest supported retire group
    localparam int unsigned TRACE_TS_W  = 32;
    localparam int unsigned LANE_IDX_W  = 2;
    localparam int unsigned LANE_PTR_W  = LANE_IDX_W + 1;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } ser_state_e;

    typedef struct packed {
        logic [TRACE_LANES-1:0]       valid;
        logic [TRACE_LANES-1:0][31:0] insn;
        logic [TRACE_LANES-1:0][31:0] addr;
        logic [TRACE_LANES-1:0]       exc;
        logic [TRACE_LANES-1:0]       intr;
        logic [4:0]                   ecause;
        logic [31:0]                  tval;
        logic                         lost;
`ifdef SWERV_TRACE_TIMESTAMP_EN
        logic [TRACE_TS_W-1:0]        ts;
`endif
    } trace_grp_t;

    // Lowest set lane at or above 'from'; MSB flags that one was found.
    function automatic logic [LANE_IDX_W:0] next_lane(input logic [TRACE_LANES-1:0] valid,
                                                      input logic [LANE_PTR_W-1:0]  from);
        logic [LANE_IDX_W:0] res;
        res = '0;
        for (int i = TRACE_LANES - 1; i >= 0; i--) begin
            if (valid[i] && (LANE_PTR_W'(i) >= from)) begin
                res = {1'b1, LANE_IDX_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/swerv_trace_fifo.sv
// Generic synchronous show-ahead FIFO: rdata always shows the head entry while non-empty.
module swerv_trace_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign level   = wr_q - rd_q;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/swerv_trace_buffer.sv
// Retire trace buffer: queues whole retire groups and emits one instruction record per beat.
// Define SWERV_TRACE_TIMESTAMP_EN to add a free-running capture timestamp and the out_ts port.
module swerv_trace_buffer
    import swerv_trace_buffer_pkg::*;
#(
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TS_W      = 32,
    localparam int unsigned LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic [NUM_LANES-1:0]   trace_valid_ip,
    input  logic [32*NUM_LANES-1:0] trace_insn_ip,
    input  logic [32*NUM_LANES-1:0] trace_address_ip,
    input  logic [NUM_LANES-1:0]   trace_exception_ip,
    input  logic [NUM_LANES-1:0]   trace_interrupt_ip,
    input  logic [4:0]             trace_ecause_ip,
    input  logic [31:0]            trace_tval_ip,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LW-1:0]          out_lane,
    output logic [31:0]            out_insn,
    output logic [31:0]            out_addr,
    output logic                   out_exc,
    output logic                   out_intr,
    output logic [4:0]             out_ecause,
    output logic [31:0]            out_tval,
    output logic                   out_lost,
`ifdef SWERV_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_ts,
`endif
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [LVL_W-1:0]       fifo_level
);

    if (NUM_LANES < 1 || NUM_LANES > TRACE_LANES || DEPTH < 2 || TS_W > TRACE_TS_W) begin : g_bad_param
        $error("swerv_trace_buffer: unsupported parameter set");
    end

    trace_grp_t            grp_in, head;
    ser_state_e            state_q;
    logic [LANE_PTR_W-1:0] lane_q;
    logic [LANE_IDX_W:0]   cur, nxt;
    logic [LANE_IDX_W-1:0] cur_idx;
    logic                  push_req, push, pop, drop, hs, last, full, empty;
    logic                  lost_q;
    logic [CNT_W-1:0]      drop_q;

`ifdef SWERV_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end
`endif

    always_comb begin
        grp_in = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            grp_in.valid[i] = trace_valid_ip[i];
            grp_in.insn[i]  = trace_insn_ip[32*i +: 32];
            grp_in.addr[i]  = trace_address_ip[32*i +: 32];
            grp_in.exc[i]   = trace_exception_ip[i];
            grp_in.intr[i]  = trace_interrupt_ip[i];
        end
        grp_in.ecause = trace_ecause_ip;
        grp_in.tval   = trace_tval_ip;
        grp_in.lost   = lost_q;
`ifdef SWERV_TRACE_TIMESTAMP_EN
        grp_in.ts     = TRACE_TS_W'(ts_q);
`endif
    end

    swerv_trace_fifo #(
        .WIDTH ($bits(trace_grp_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (grp_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign cur     = next_lane(head.valid, lane_q);
    assign cur_idx = cur[LANE_IDX_W-1:0];
    assign nxt     = next_lane(head.valid, {1'b0, cur_idx} + LANE_PTR_W'(1));

    assign out_valid = (state_q == StEmit);
    assign hs        = out_valid && out_ready;
    assign last      = !nxt[LANE_IDX_W];
    assign pop       = hs && last;
    assign push_req  = trace_en && |trace_valid_ip;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lane_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (push || !empty) state_q <= StEmit;
                end
                StEmit: begin
                    if (hs) begin
                        if (last) begin
                            lane_q <= '0;
                            if (fifo_level == LVL_W'(1) && !push) state_q <= StIdle;
                        end else begin
                            lane_q <= {1'b0, cur_idx} + LANE_PTR_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The lost marker rides with the next accepted group rather than the record already queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_q <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            lost_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end else if (push) begin
            lost_q <= 1'b0;
        end
    end

    assign drop_cnt = drop_q;

    always_comb begin
        out_lane   = '0;
        out_insn   = '0;
        out_addr   = '0;
        out_exc    = 1'b0;
        out_intr   = 1'b0;
        out_ecause = '0;
        out_tval   = '0;
        out_lost   = 1'b0;
`ifdef SWERV_TRACE_TIMESTAMP_EN
        out_ts     = '0;
`endif
        if (out_valid) begin
            out_lane   = LW'(cur_idx);
            out_insn   = head.insn[cur_idx];
            out_addr   = head.addr[cur_idx];
            out_exc    = head.exc[cur_idx];
            out_intr   = head.intr[cur_idx];
            out_ecause = head.ecause;
            out_tval   = head.tval;
            out_lost   = head.lost && (lane_q == '0);
`ifdef SWERV_TRACE_TIMESTAMP_EN
            out_ts     = head.ts[TS_W-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_swerv_trace_buffer.sv
// Directed self-checking bench for swerv_trace_buffer (3 lanes, depth 8).
module tb_swerv_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic [2:0]  trace_valid_ip;
    logic [95:0] trace_insn_ip;
    logic [95:0] trace_address_ip;
    logic [2:0]  trace_exception_ip;
    logic [2:0]  trace_interrupt_ip;
    logic [4:0]  trace_ecause_ip;
    logic [31:0] trace_tval_ip;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic        out_exc;
    logic        out_intr;
    logic [4:0]  out_ecause;
    logic [31:0] out_tval;
    logic        out_lost;
`ifdef SWERV_TRACE_TIMESTAMP_EN
    logic [31:0] out_ts;
`endif
    logic [15:0] drop_cnt;
    logic [3:0]  fifo_level;

    swerv_trace_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .trace_en           (trace_en),
        .trace_valid_ip     (trace_valid_ip),
        .trace_insn_ip      (trace_insn_ip),
        .trace_address_ip   (trace_address_ip),
        .trace_exception_ip (trace_exception_ip),
        .trace_interrupt_ip (trace_interrupt_ip),
        .trace_ecause_ip    (trace_ecause_ip),
        .trace_tval_ip      (trace_tval_ip),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_lane           (out_lane),
        .out_insn           (out_insn),
        .out_addr           (out_addr),
        .out_exc            (out_exc),
        .out_intr           (out_intr),
        .out_ecause         (out_ecause),
        .out_tval           (out_tval),
        .out_lost           (out_lost),
`ifdef SWERV_TRACE_TIMESTAMP_EN
        .out_ts             (out_ts),
`endif
        .drop_cnt           (drop_cnt),
        .fifo_level         (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rec_insn   [16];
    logic [31:0] rec_tval   [16];
    logic [31:0] rec_ts     [16];
    logic [4:0]  rec_ecause [16];
    logic [1:0]  rec_lane   [16];
    logic        rec_lost   [16];
    logic        rec_exc    [16];
    logic        rec_intr   [16];
    int          n_rec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_grp(input logic [2:0] v, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] i2);
        trace_valid_ip     = v;
        trace_insn_ip      = {i2, i1, i0};
        trace_address_ip   = {32'h8000_0008, 32'h8000_0004, 32'h8000_0000};
        trace_exception_ip = '0;
        trace_interrupt_ip = '0;
        trace_ecause_ip    = '0;
        trace_tval_ip      = '0;
    endtask

    task automatic clr_grp();
        set_grp(3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    // Samples each presented record at the falling edge until out_valid drops (bounded).
    task automatic collect(input int max_cycles);
        n_rec = 0;
        for (int c = 0; c < max_cycles; c++) begin
            if (!out_valid) break;
            if (n_rec < 16) begin
                rec_insn[n_rec]   = out_insn;
                rec_tval[n_rec]   = out_tval;
                rec_ecause[n_rec] = out_ecause;
                rec_lane[n_rec]   = out_lane;
                rec_lost[n_rec]   = out_lost;
                rec_exc[n_rec]    = out_exc;
                rec_intr[n_rec]   = out_intr;
`ifdef SWERV_TRACE_TIMESTAMP_EN
                rec_ts[n_rec]     = out_ts;
`else
                rec_ts[n_rec]     = 32'h0;
`endif
            end
            n_rec++;
            @(negedge clk);
        end
        check("collect_drained", {63'h0, out_valid}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        trace_en  = 1'b1;
        out_ready = 1'b0;
        clr_grp();
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_insn", out_insn, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_lost", out_lost, 0);

        // 1: two-lane group, ready high
        out_ready = 1'b1;
        set_grp(3'b101, 32'h0000_0013, 32'h0, 32'h00A0_0093);
        check("t1_pre_valid", out_valid, 0);
        @(negedge clk);
        clr_grp();
        check("t1_valid", out_valid, 1);
        check("t1_lane0", out_lane, 0);
        check("t1_insn0", out_insn, 32'h0000_0013);
        check("t1_addr0", out_addr, 32'h8000_0000);
        check("t1_level1", fifo_level, 1);
        @(negedge clk);
        check("t1_lane2", out_lane, 2);
        check("t1_insn2", out_insn, 32'h00A0_0093);
        check("t1_addr2", out_addr, 32'h8000_0008);
        check("t1_level_hold", fifo_level, 1);
        @(negedge clk);
        check("t1_idle", out_valid, 0);
        check("t1_level0", fifo_level, 0);

        // 2: backpressure holds the record
        out_ready = 1'b0;
        set_grp(3'b011, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0);
        @(negedge clk);
        clr_grp();
        for (int c = 0; c < 5; c++) begin
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_lane", out_lane, 0);
            check("t2_hold_insn", out_insn, 32'hAAAA_0001);
            check("t2_hold_level", fifo_level, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_lane1", out_lane, 1);
        check("t2_insn1", out_insn, 32'hBBBB_0002);
        @(negedge clk);
        check("t2_idle", out_valid, 0);

        // 3: overflow, drop count and lost marker
        out_ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            set_grp(3'b001, 32'(k), 32'h0, 32'h0);
            @(negedge clk);
        end
        clr_grp();
        check("t3_level_full", fifo_level, 8);
        check("t3_drop3", drop_cnt, 3);
        check("t3_first_lost", out_lost, 0);
        check("t3_first_insn", out_insn, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_second_insn", out_insn, 1);
        check("t3_second_lost", out_lost, 0);
        check("t3_level7", fifo_level, 7);
        set_grp(3'b001, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        clr_grp();
        check("t3_level_pushpop", fifo_level, 7);
        collect(20);
        check("t3_nrec", n_rec, 7);
        check("t3_rec5_insn", rec_insn[5], 7);
        check("t3_rec5_lost", rec_lost[5], 0);
        check("t3_rec6_insn", rec_insn[6], 32'h100);
        check("t3_rec6_lost", rec_lost[6], 1);
        check("t3_drop_hold", drop_cnt, 3);

        // 4: full FIFO, pop and push in the same cycle
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_grp(3'b001, 32'h200 + 32'(k), 32'h0, 32'h0);
            @(negedge clk);
        end
        check("t4_level_full", fifo_level, 8);
        set_grp(3'b001, 32'h300, 32'h0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        clr_grp();
        check("t4_drop_same", drop_cnt, 3);
        check("t4_level_same", fifo_level, 8);
        collect(20);
        check("t4_nrec", n_rec, 8);
        check("t4_rec0_insn", rec_insn[0], 32'h201);
        check("t4_rec7_insn", rec_insn[7], 32'h300);
        check("t4_rec7_lost", rec_lost[7], 0);

        // 5: exception/interrupt fields, then capture disabled
        set_grp(3'b111, 32'h1, 32'h2, 32'h3);
        trace_exception_ip = 3'b010;
        trace_interrupt_ip = 3'b100;
        trace_ecause_ip    = 5'd2;
        trace_tval_ip      = 32'hDEAD_BEEF;
        @(negedge clk);
        clr_grp();
        collect(10);
        check("t5_nrec", n_rec, 3);
        check("t5_rec0_exc", rec_exc[0], 0);
        check("t5_rec1_lane", rec_lane[1], 1);
        check("t5_rec1_exc", rec_exc[1], 1);
        check("t5_rec1_ecause", rec_ecause[1], 2);
        check("t5_rec1_tval", rec_tval[1], 32'hDEAD_BEEF);
        check("t5_rec2_intr", rec_intr[2], 1);
        check("t5_rec1_intr", rec_intr[1], 0);
        trace_en = 1'b0;
        set_grp(3'b111, 32'h4, 32'h5, 32'h6);
        repeat (3) @(negedge clk);
        check("t5_dis_valid", out_valid, 0);
        check("t5_dis_level", fifo_level, 0);
        check("t5_dis_drop", drop_cnt, 3);
        clr_grp();
        trace_en = 1'b1;

        // 6: asynchronous reset mid-record, then timestamped capture
        out_ready = 1'b0;
        set_grp(3'b111, 32'hA, 32'hB, 32'hC);
        @(negedge clk);
        clr_grp();
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_lane1", out_lane, 1);
        check("t6_insn1", out_insn, 32'hB);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_insn", out_insn, 0);
        check("t6_rst_lane", out_lane, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        set_grp(3'b111, 32'h11, 32'h22, 32'h33);
        @(negedge clk);
        clr_grp();
        collect(10);
        check("t6_nrec", n_rec, 3);
        check("t6_rec0_insn", rec_insn[0], 32'h11);
        check("t6_rec2_insn", rec_insn[2], 32'h33);
        check("t6_rec0_lost", rec_lost[0], 0);
`ifdef SWERV_TRACE_TIMESTAMP_EN
        for (int i = 0; i < 3; i++) check("t6_ts", rec_ts[i], 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
